// File: rtl/wts_timer_scheduler.sv
// Two independent tick-driven down-counting timers that emit indexed one-cycle expiry pulses.
// The trigger is registered one clock after the expiring tick. Start/stop/repeat are set through CONTROL.
module wts_timer_scheduler (
  input  logic       clk,
  input  logic       nreset,
  input  logic       tick,
  input  logic       reg_wr,
  input  logic [1:0] reg_address,
  input  logic [7:0] reg_wdata,
  output logic       timer1_trigger,
  output logic       timer2_trigger,
  output logic [6:0] timer1_address,
  output logic [6:0] timer2_address,
  output logic       timer1_running,
  output logic       timer2_running
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state     [2];
  logic [7:0] period    [2];
  logic [7:0] count     [2];
  logic [6:0] event_cnt [2];
  logic [6:0] addr_q    [2];
  logic       rep       [2];
  logic       trig_q    [2];

  logic       ctl_wr;
  logic       start     [2];
  logic       stop      [2];
  logic       expire    [2];
  logic       rep_nx    [2];
  logic [7:0] period_nx [2];

  assign ctl_wr = reg_wr && (reg_address == 2'd2);

  // Stop dominates start; a start or stop in an expiring cycle swallows the expiry.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      start[n]     = ctl_wr && reg_wdata[4*n] && !reg_wdata[4*n+1];
      stop[n]      = ctl_wr && reg_wdata[4*n+1];
      rep_nx[n]    = ctl_wr ? reg_wdata[4*n+2] : rep[n];
      period_nx[n] = (reg_wr && (reg_address == 2'(n))) ? reg_wdata : period[n];
      expire[n]    = (state[n] == RUN) && tick && (count[n] == 8'd1) && !start[n] && !stop[n];
    end
  end

  // A count of 0 decrements through 255, so period 0 lasts 256 ticks.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int n = 0; n < 2; n++) begin
        state[n]     <= IDLE;
        period[n]    <= 8'd0;
        count[n]     <= 8'd0;
        event_cnt[n] <= 7'd0;
        addr_q[n]    <= 7'd0;
        rep[n]       <= 1'b0;
        trig_q[n]    <= 1'b0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        period[n] <= period_nx[n];
        rep[n]    <= rep_nx[n];
        trig_q[n] <= expire[n];
        if (stop[n]) begin
          state[n] <= IDLE;
        end else if (start[n]) begin
          state[n]     <= RUN;
          count[n]     <= period_nx[n];
          event_cnt[n] <= 7'd0;
        end else if (expire[n]) begin
          addr_q[n]    <= event_cnt[n];
          event_cnt[n] <= event_cnt[n] + 7'd1;
          if (rep_nx[n]) count[n] <= period_nx[n];
          else           state[n] <= IDLE;
        end else if ((state[n] == RUN) && tick) begin
          count[n] <= count[n] - 8'd1;
        end
      end
    end
  end

  assign timer1_trigger = trig_q[0];
  assign timer2_trigger = trig_q[1];
  assign timer1_address = addr_q[0];
  assign timer2_address = addr_q[1];
  assign timer1_running = (state[0] == RUN);
  assign timer2_running = (state[1] == RUN);

endmodule

// File: doc/wts_timer_scheduler.md
WTS_TIMER_SCHEDULER -- requirements
Module: wts_timer_scheduler

Interface
REQ-001 SHALL have port nreset, input, 1, asynchronous active-low reset.
REQ-002 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-003 SHALL have port tick, input, 1, one-cycle sample-rate strobe that is the timebase.
REQ-004 SHALL have port reg_wr, input, 1, one-cycle register write strobe.
REQ-005 SHALL have port reg_address, input, 2, register select: 0=PERIOD1, 1=PERIOD2, 2=CONTROL, 3=ignored.
REQ-006 SHALL have port reg_wdata, input, 8, write data.
REQ-007 SHALL have ports timer1_trigger and timer2_trigger, output, 1 each, one-cycle expiry pulses.
REQ-008 SHALL have ports timer1_address and timer2_address, output, 7 each, event index, valid while the matching trigger is high.
REQ-009 SHALL have ports timer1_running and timer2_running, output, 1 each, high in RUN state.

Function
REQ-010 SHALL keep per timer n: period register (8 bit), repeat bit, down-counter (8 bit), event counter (7 bit), and a 2-state FSM IDLE/RUN.
REQ-011 PERIOD write SHALL update the period register only; a running counter is unaffected until its next reload.
REQ-012 CONTROL bits SHALL be: bit0 start1, bit1 stop1, bit2 repeat1, bit4 start2, bit5 stop2, bit6 repeat2; bits 3,7 ignored; start/stop self-clearing, repeat stored.
REQ-013 Start SHALL, from any state: load down-counter with period, clear event counter to 0, enter RUN (restart if already running).
REQ-014 Stop SHALL enter IDLE; down-counter and event counter hold; no trigger issued.
REQ-015 Start and stop set together for one timer SHALL act as stop.
REQ-016 In RUN, each tick with down-counter != 1 SHALL decrement it; ticks in IDLE SHALL be ignored.
REQ-017 In RUN, a tick with down-counter == 1 SHALL, on the next clock edge, assert timerN_trigger for exactly one cycle with timerN_address = event counter, then increment event counter (127 wraps to 0).
REQ-018 On expiry in repeat mode SHALL reload down-counter from period and stay RUN; in one-shot mode SHALL enter IDLE.
REQ-019 Period value 0 SHALL be treated as 256 ticks; period 1 SHALL expire on every tick.
REQ-020 Trigger latency SHALL be exactly one clock after the expiring tick cycle; no other output change is delayed.
REQ-021 Both timers expiring on the same tick SHALL pulse both triggers in the same cycle; timers are fully independent.
REQ-022 A CONTROL write in the same cycle as an expiring tick for that timer SHALL take priority: stop suppresses the trigger; start suppresses it and restarts.
REQ-023 A PERIOD write in the same cycle as a reload SHALL make the reload use the new value.
REQ-024 timerN_address SHALL hold its last value when trigger is low.

Reset
REQ-025 On nreset low, asynchronously: FSMs IDLE, periods 0, repeat bits 0, down-counters 0, event counters 0, all triggers 0, addresses 0, running 0.
REQ-026 Reset asserted mid-count SHALL abort with no trigger pulse; after release no trigger until a new start.

Verification
REQ-027 PERIOD1=3, CONTROL=0x05, 7 ticks -> timer1_trigger after ticks 3 and 6, addresses 0 then 1; running1 stays 1.
REQ-028 PERIOD2=2, CONTROL=0x10 (one-shot), 5 ticks -> one pulse after tick 2, address 0; running2 falls to 0; no further pulses.
REQ-029 PERIOD1=1, PERIOD2=1, CONTROL=0x55, 130 ticks -> both triggers every tick in same cycle; addresses run 0..127, 0, 1.
REQ-030 PERIOD1=0 repeat, 256 ticks -> exactly one pulse at tick 256; CONTROL=0x03 mid-run -> IDLE, no pulse.
REQ-031 Running timer1 with count==1, stop written on same cycle as tick -> no trigger; nreset pulsed mid-run of timer2 -> all outputs 0, no trigger afterwards.
